bcd_stopwatch: RTL and testbench
================================

// Module: bcd_stopwatch
// PURPOSE
//  Upstream data source for the 4-digit 7-segment display block: a debounced
//  start/stop + clear stopwatch counting seconds and hundredths (SS.hh) in BCD.
//  Consumes the display block's ce1ms strobe as its only timebase.
//  Drives the display's 16-bit digit word and decimal-point selector.
// PARAMETERS
//  DEB_MS    20  consecutive ce1ms samples a button level must hold to be accepted (>=1)
//  TICKS     10  ce1ms strobes per count LSB (10 -> 0.01 s), >=1
//  SAT       0   0: wrap 99.99->00.00; 1: saturate at 99.99 and stop
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  ce1ms      in   1   1-clk strobe once per ms, from the display block
//  btn_start  in   1   raw start/stop button, active high, asynchronous to clk
//  btn_clr    in   1   raw clear button, active high, asynchronous to clk
//  dat        out  16  BCD digits {S1,S0,H1,H0}; dat[3:0] = hundredths units
//  ptr        out  2   decimal-point digit index for the display, fixed 2'd2 (after S0)
//  running    out  1   high while in RUN
//  ovf        out  1   sticky: count passed/reached 99.99
// BEHAVIOUR
//  Reset (async, rst_n=0): dat=16'h0000, ptr=2'd2, running=0, ovf=0, state=IDLE,
//   prescaler=0, debounce counters=0, accepted button levels=0, sync flops=0.
//  Input sync: each button through 2 flops before any other use.
//  Debounce: per button, evaluated only on ce1ms cycles. If synced level !=
//   accepted level, increment counter; on reaching DEB_MS, update accepted level,
//   counter=0. If equal, counter=0. Press pulse = 1-clk pulse on 0->1 of accepted level.
//   Release edges generate nothing. Width of counter = clog2(DEB_MS+1).
//  FSM (states IDLE, RUN, HOLD), evaluated on press pulses:
//   IDLE: start -> RUN.  clr -> IDLE (no-op).
//   RUN : start -> HOLD. clr ignored.
//   HOLD: start -> RUN.  clr -> IDLE.
//   Same-cycle start+clr: IDLE -> IDLE; HOLD -> IDLE (clr wins); RUN -> HOLD.
//   Entering IDLE: dat=0, prescaler=0, ovf=0 on the same clk edge.
//  Prescaler: RUN and ce1ms: counts 0..TICKS-1; when it wraps to 0, count LSB
//   increments on that same edge (dat valid 1 clk after the ce1ms cycle).
//   HOLD: prescaler and dat frozen. Width = clog2(TICKS).
//  BCD count: 4 cascaded decade digits, each 0..9; a digit carries to the next
//   when it is 9 and incremented. Never any nibble value > 9.
//  Overflow at 99.99 + 1 LSB:
//   SAT=0: dat -> 16'h0000, ovf=1, stays RUN.
//   SAT=1: dat stays 16'h9999, ovf=1, state -> HOLD on the same edge;
//    a start press from HOLD while dat==9999 with SAT=1 is ignored (clr required).
//  running = (state==RUN), registered together with the state.
//  ptr constant 2'd2 out of reset; all outputs registered, no combinational paths.
//  ce1ms low: only sync flops and FSM (on pending press pulses) may change.
// TESTING  (bench: ce1ms 1 clk in 4; DEB_MS=2, TICKS=2 unless noted)
//  1 Reset: rst_n=0 mid-RUN with dat=16'h0123 -> dat=0, running=0, ovf=0, ptr=2 immediately, no clk needed.
//  2 Bounce: btn_start toggles every ce1ms for 10 ms, then held 1 for 3 ms -> exactly one
//    press, running=1 from 2 stable samples; release causes no state change.
//  3 Count: RUN for 200 ce1ms -> dat=16'h0100; start press -> HOLD, dat frozen over 50 ce1ms; start -> resumes from 0100.
//  4 Clear rules: clr in RUN -> ignored, counting continues; clr in HOLD -> dat=0, IDLE; start+clr same clk in HOLD -> IDLE, in RUN -> HOLD.
//  5 Wrap SAT=0: preload by running to 16'h9999, one more LSB -> dat=16'h0000, ovf=1, running=1; clr from HOLD clears ovf.
//  6 Saturate SAT=1: at 99.99+1 LSB -> dat=16'h9999, ovf=1, running=0; start ignored; clr -> dat=0, IDLE.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// SS.hh stopwatch in BCD: debounced start/stop and clear buttons, counted off
// the display's ce1ms strobe, feeding the 4-digit display as {S1,S0,H1,H0}.
module bcd_stopwatch #(
   parameter int DEB_MS = 20,
   parameter int TICKS  = 10,
   parameter int SAT    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce1ms,
   input  logic        btn_start,
   input  logic        btn_clr,
   output logic [15:0] dat,
   output logic [1:0]  ptr,
   output logic        running,
   output logic        ovf
);

   localparam int DW = $clog2(DEB_MS + 1);
   localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MS - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS - 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   // Button vectors: bit 0 = start, bit 1 = clear.
   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic [1:0]    acc_q, acc_d;
   logic [1:0]    press_q, press_d;
   logic [DW-1:0] cnt_q [2];
   logic [DW-1:0] cnt_d [2];

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   dat_q, dat_d;
   logic          running_q, running_d;
   logic          ovf_q, ovf_d;
   logic [1:0]    ptr_q;
   logic [16:0]   inc;

   // Returns {carry out of the top decade, incremented BCD word}.
   function automatic logic [16:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return {c, r};
   endfunction

   assign inc = bcd_inc(dat_q);

   always_comb begin
      sync1_d = {btn_clr, btn_start};
      sync2_d = sync1_q;
      acc_d   = acc_q;
      press_d = '0;
      cnt_d   = cnt_q;
      if (ce1ms) begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != acc_q[i]) begin
               if (cnt_q[i] == DEB_LAST) begin
                  acc_d[i]   = sync2_q[i];
                  press_d[i] = sync2_q[i];
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + DW'(1);
               end
            end else begin
               cnt_d[i] = '0;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      dat_d   = dat_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (press_q[0] && !press_q[1]) state_d = RUN;
         RUN:  if (press_q[0]) state_d = HOLD;
         HOLD: begin
            if (press_q[1]) begin
               state_d = IDLE;
            end else if (press_q[0] && !(SAT != 0 && dat_q == 16'h9999)) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q == RUN && ce1ms) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (inc[16]) begin
               ovf_d = 1'b1;
               if (SAT != 0) begin
                  dat_d   = 16'h9999;
                  state_d = HOLD;
               end else begin
                  dat_d = inc[15:0];
               end
            end else begin
               dat_d = inc[15:0];
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
      // Any entry into IDLE (or staying there) forces a clean count.
      if (state_d == IDLE) begin
         dat_d = '0;
         pre_d = '0;
         ovf_d = 1'b0;
      end
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         acc_q     <= '0;
         press_q   <= '0;
         cnt_q[0]  <= '0;
         cnt_q[1]  <= '0;
         state_q   <= IDLE;
         pre_q     <= '0;
         dat_q     <= '0;
         running_q <= 1'b0;
         ovf_q     <= 1'b0;
         ptr_q     <= 2'd2;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         acc_q     <= acc_d;
         press_q   <= press_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         pre_q     <= pre_d;
         dat_q     <= dat_d;
         running_q <= running_d;
         ovf_q     <= ovf_d;
         ptr_q     <= 2'd2;
      end
   end

   assign dat     = dat_q;
   assign ptr     = ptr_q;
   assign running = running_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: three instances (ticks 2/1/1, wrap/wrap/saturate)
// compared against a reference model kept in integer milliseconds.
module tb_bcd_stopwatch;

   localparam int TK [3] = '{2, 1, 1};
   localparam int SP [3] = '{0, 0, 1};
   localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce1ms = 1'b0;
   logic        bs [2];
   logic        bc [2];
   logic [15:0] dat_o [3];
   logic [1:0]  ptr_o [3];
   logic        run_o [3];
   logic        ovf_o [3];

   int checks = 0;
   int errors = 0;

   // Reference model state: milliseconds spent running since the last clear.
   int          m_st [3];
   int          m_ms [3];
   logic        m_s1 [3][2];
   logic        m_s2 [3][2];
   logic        m_acc [3][2];
   logic        m_pulse [3][2];
   logic [1:0]  m_hist [3][2];

   always #5 clk = ~clk;

   bcd_stopwatch #(.DEB_MS(2), .TICKS(2), .SAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .btn_start(bs[0]), .btn_clr(bc[0]),
      .dat(dat_o[0]), .ptr(ptr_o[0]), .running(run_o[0]), .ovf(ovf_o[0]));
   bcd_stopwatch #(.DEB_MS(2), .TICKS(1), .SAT(0)) u1 (
      .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .btn_start(bs[1]), .btn_clr(bc[1]),
      .dat(dat_o[1]), .ptr(ptr_o[1]), .running(run_o[1]), .ovf(ovf_o[1]));
   bcd_stopwatch #(.DEB_MS(2), .TICKS(1), .SAT(1)) u2 (
      .clk(clk), .rst_n(rst_n), .ce1ms(ce1ms), .btn_start(bs[1]), .btn_clr(bc[1]),
      .dat(dat_o[2]), .ptr(ptr_o[2]), .running(run_o[2]), .ovf(ovf_o[2]));

   initial begin
      int n;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         n = (n + 1) % 4;
         ce1ms = (n == 3);
      end
   end

   function automatic int m_ticks(int i);
      return m_ms[i] / TK[i];
   endfunction

   function automatic int m_disp(int i);
      int t;
      t = m_ticks(i);
      if (SP[i] != 0) return (t > 9999) ? 9999 : t;
      return t % 10000;
   endfunction

   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 3; i++) begin
         m_st[i] = S_IDLE;
         m_ms[i] = 0;
         for (int b = 0; b < 2; b++) begin
            m_s1[i][b] = 1'b0; m_s2[i][b] = 1'b0; m_acc[i][b] = 1'b0;
            m_pulse[i][b] = 1'b0; m_hist[i][b] = 2'b00;
         end
      end
   endtask

   task automatic m_step();
      for (int i = 0; i < 3; i++) begin
         int   g, st, ns, dold;
         logic start, clr, raw;
         g     = (i == 0) ? 0 : 1;
         st    = m_st[i];
         start = m_pulse[i][0];
         clr   = m_pulse[i][1];
         dold  = m_disp(i);
         ns    = st;
         if (st == S_IDLE && start && !clr) ns = S_RUN;
         if (st == S_RUN && start) ns = S_HOLD;
         if (st == S_HOLD) begin
            if (clr) ns = S_IDLE;
            else if (start && !(SP[i] != 0 && dold == 9999)) ns = S_RUN;
         end
         if (st == S_RUN && ce1ms) begin
            m_ms[i] = m_ms[i] + 1;
            if (SP[i] != 0 && m_ticks(i) >= 10000) ns = S_HOLD;
         end
         if (ns == S_IDLE) m_ms[i] = 0;
         m_st[i] = ns;
         for (int b = 0; b < 2; b++) begin
            m_pulse[i][b] = 1'b0;
            if (ce1ms) begin
               m_hist[i][b] = {m_hist[i][b][0], m_s2[i][b]};
               // Accept once the last two samples both disagree with the accepted level.
               if (m_hist[i][b] == {2{~m_acc[i][b]}}) begin
                  m_acc[i][b]   = ~m_acc[i][b];
                  m_pulse[i][b] = m_acc[i][b];
               end
            end
            raw = (b == 0) ? bs[g] : bc[g];
            m_s2[i][b] = m_s1[i][b];
            m_s1[i][b] = raw;
         end
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_u%0d_dat", tag, i), dat_o[i], to_bcd(m_disp(i)));
         chk($sformatf("%s_u%0d_run", tag, i), 16'(run_o[i]), 16'(m_st[i] == S_RUN));
         chk($sformatf("%s_u%0d_ovf", tag, i), 16'(ovf_o[i]), 16'(m_ticks(i) >= 10000));
         chk($sformatf("%s_u%0d_ptr", tag, i), 16'(ptr_o[i]), 16'd2);
      end
   endtask

   task automatic wait_clk(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(int g, logic s, logic c);
      bs[g] = s;
      bc[g] = c;
      wait_clk(16);
      bs[g] = 1'b0;
      bc[g] = 1'b0;
      wait_clk(16);
   endtask

   task automatic wait_dat(int i, logic [15:0] v, int lim, string tag);
      int n;
      n = 0;
      while (dat_o[i] !== v && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 16'(dat_o[i] === v), 16'd1);
   endtask

   task automatic wait_run(int i, int lim, string tag);
      int n;
      n = 0;
      while (run_o[i] !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 16'(run_o[i]), 16'd1);
   endtask

   initial begin
      logic [15:0] frozen;
      int          k;
      bs[0] = 1'b0; bs[1] = 1'b0; bc[0] = 1'b0; bc[1] = 1'b0;
      rst_n = 1'b0;
      wait_clk(3);
      check_all("rst");
      rst_n = 1'b1;

      // Asynchronous reset in the middle of a run.
      press(0, 1'b1, 1'b0);
      wait_dat(0, 16'h0123, 2000, "t1_reach");
      chk("t1_run_before", 16'(run_o[0]), 16'd1);
      check_all("t1_pre");
      #2 rst_n = 1'b0;
      #1;
      chk("t1_dat", dat_o[0], 16'h0000);
      chk("t1_run", 16'(run_o[0]), 16'd0);
      chk("t1_ovf", 16'(ovf_o[0]), 16'd0);
      chk("t1_ptr", 16'(ptr_o[0]), 16'd2);
      check_all("t1_post");
      @(negedge clk);
      rst_n = 1'b1;
      wait_clk(4);

      // Bouncing start button: only the final stable level counts.
      for (int t = 0; t < 10; t++) begin
         bs[0] = (t % 2 == 0);
         wait_clk(4);
      end
      chk("t2_bounce_idle", 16'(run_o[0]), 16'd0);
      bs[0] = 1'b1;
      wait_clk(12);
      chk("t2_one_press", 16'(run_o[0]), 16'd1);
      check_all("t2_held");
      bs[0] = 1'b0;
      wait_clk(16);
      chk("t2_release", 16'(run_o[0]), 16'd1);
      check_all("t2_rel");

      // Clear needs HOLD first; then an exact 200 ms run from zero.
      press(0, 1'b1, 1'b0);
      chk("t3_hold0", 16'(run_o[0]), 16'd0);
      press(0, 1'b0, 1'b1);
      chk("t4_clr_hold", dat_o[0], 16'h0000);
      check_all("t4_clr_hold");
      bs[0] = 1'b1;
      wait_run(0, 100, "t3_start");
      bs[0] = 1'b0;
      k = 0;
      while (k < 200) begin
         if (ce1ms) k++;
         @(negedge clk);
      end
      chk("t3_0100", dat_o[0], 16'h0100);
      check_all("t3_0100");
      press(0, 1'b1, 1'b0);
      frozen = to_bcd(m_disp(0));
      check_all("t3_hold");
      wait_clk(200);
      chk("t3_frozen", dat_o[0], frozen);
      bs[0] = 1'b1;
      wait_run(0, 100, "t3_resume");
      bs[0] = 1'b0;
      chk("t3_resume_dat", dat_o[0], frozen);

      // Clear ignored while running; combined presses.
      press(0, 1'b0, 1'b1);
      chk("t4_clr_run", 16'(run_o[0]), 16'd1);
      wait_clk(40);
      check_all("t4_counting");
      press(0, 1'b1, 1'b1);
      chk("t4_both_run", 16'(run_o[0]), 16'd0);
      chk("t4_both_run_dat", 16'(dat_o[0] != 16'h0000), 16'd1);
      check_all("t4_both_run");
      press(0, 1'b1, 1'b1);
      chk("t4_both_hold", dat_o[0], 16'h0000);
      chk("t4_both_hold_run", 16'(run_o[0]), 16'd0);
      press(0, 1'b1, 1'b1);
      chk("t4_both_idle", 16'(run_o[0]), 16'd0);
      check_all("t4_end");

      // Random button activity with bounce on u0.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) bs[0] = ~bs[0];
         if ($urandom_range(0, 39) == 0) bc[0] = ~bc[0];
         if (c % 4 == 0) check_all("rnd");
      end
      bs[0] = 1'b0;
      bc[0] = 1'b0;
      wait_clk(16);
      check_all("rnd_end");

      // Run u1/u2 to the top of the range.
      bs[1] = 1'b1;
      wait_clk(16);
      bs[1] = 1'b0;
      wait_dat(1, 16'h9999, 45000, "t5_reach");
      chk("t6_reach", dat_o[2], 16'h9999);
      check_all("t5_top");
      wait_dat(1, 16'h0000, 20, "t5_wrap");
      @(negedge clk);
      chk("t5_dat", dat_o[1], 16'h0000);
      chk("t5_ovf", 16'(ovf_o[1]), 16'd1);
      chk("t5_run", 16'(run_o[1]), 16'd1);
      chk("t6_dat", dat_o[2], 16'h9999);
      chk("t6_ovf", 16'(ovf_o[2]), 16'd1);
      chk("t6_run", 16'(run_o[2]), 16'd0);
      check_all("t56_ovf");
      press(1, 1'b1, 1'b0);
      chk("t5_hold", 16'(run_o[1]), 16'd0);
      chk("t6_start_ign", 16'(run_o[2]), 16'd0);
      chk("t6_start_dat", dat_o[2], 16'h9999);
      check_all("t56_start");
      press(1, 1'b0, 1'b1);
      chk("t5_clr_ovf", 16'(ovf_o[1]), 16'd0);
      chk("t5_clr_dat", dat_o[1], 16'h0000);
      chk("t6_clr_dat", dat_o[2], 16'h0000);
      chk("t6_clr_ovf", 16'(ovf_o[2]), 16'd0);
      check_all("t56_clr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
